// File: rtl/fft_agu_pkg.sv
// Shared types and helpers for the radix-2 DIT FFT address generator.
package fft_agu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned FN_W  = 32;
  localparam int unsigned FN_IW = 5;

  // Rotate the low 'width' bits of value left by 'amount'; upper bits return 0.
  function automatic logic [FN_W-1:0] rotl(input logic [FN_W-1:0] value,
                                            input int unsigned    amount,
                                            input int unsigned    width);
    logic [FN_W-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < FN_W; i++) begin
      if (i < width) res[FN_IW'((i + amount) % width)] = value[FN_IW'(i)];
    end
    return res;
  endfunction

  // Mask with the top s bits of a width-bit field set.
  function automatic logic [FN_W-1:0] stage_mask(input int unsigned s,
                                                  input int unsigned width);
    logic [FN_W-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < FN_W; i++) begin
      if ((i < width) && (i + s >= width)) res[FN_IW'(i)] = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fft_agu_wb_pipe.sv
// DEPTH x WIDTH delay line carrying read strobes/addresses to the write side.
module fft_agu_wb_pipe #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sr [DEPTH];

  // Shift register with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < int'(DEPTH); i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/fft_agu_param.sv
// In-place radix-2 DIT FFT address generator (bit-reversed input order).
// Optional inverse-transform support: define FFT_AGU_IFFT_EN.
module fft_agu_param
  import fft_agu_pkg::*;
#(
  parameter  int unsigned LOG2N    = 5,
  parameter  int unsigned BFLY_LAT = 3,
  localparam int unsigned AW       = LOG2N,
  localparam int unsigned TW       = LOG2N - 1,
  localparam int unsigned SW       = $clog2(LOG2N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fft_start,
`ifdef FFT_AGU_IFFT_EN
  input  logic          fft_inverse,
  output logic          tw_conj,
`endif
  output logic          fft_busy,
  output logic          fft_done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr_a,
  output logic [AW-1:0] rd_addr_b,
  output logic [TW-1:0] twiddle_address,
  output logic          mem_wr,
  output logic [AW-1:0] wr_addr_a,
  output logic [AW-1:0] wr_addr_b,
  output logic [SW-1:0] stage
);

  localparam int unsigned DW = $clog2(BFLY_LAT) + 1;
  localparam int unsigned PW = 1 + 2 * AW;
  localparam logic [TW-1:0] J_LAST = '1;
  localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
  localparam logic [DW-1:0] D_LAST = DW'(BFLY_LAT - 1);

  state_t        state, state_nx;
  logic [TW-1:0] j_q, j_nx;
  logic [SW-1:0] s_q, s_nx;
  logic [DW-1:0] d_q, d_nx;
  logic          start_prev;
  logic          start_edge_c;

  logic          rd_en_nx, busy_nx, done_nx;
  logic [AW-1:0] addr_a_nx, addr_b_nx;
  logic [TW-1:0] tw_nx;
  logic [SW-1:0] stage_nx;
  logic [PW-1:0] wb_q;

  assign start_edge_c = fft_start & ~start_prev;

  // State, counters and start-edge history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      j_q        <= '0;
      s_q        <= '0;
      d_q        <= '0;
      start_prev <= 1'b0;
    end else begin
      state      <= state_nx;
      j_q        <= j_nx;
      s_q        <= s_nx;
      d_q        <= d_nx;
      start_prev <= fft_start;
    end
  end

  // Next state: RUN walks j over N/2 butterflies, DRAIN waits out the pipeline
  always_comb begin
    state_nx = state;
    j_nx     = j_q;
    s_nx     = s_q;
    d_nx     = d_q;
    unique case (state)
      ST_IDLE: begin
        if (start_edge_c) begin
          state_nx = ST_RUN;
          j_nx     = '0;
          s_nx     = '0;
        end
      end
      ST_RUN: begin
        if (j_q == J_LAST) begin
          state_nx = ST_DRAIN;
          d_nx     = '0;
        end else begin
          j_nx = j_q + TW'(1);
        end
      end
      ST_DRAIN: begin
        if (d_q == D_LAST) begin
          if (s_q < S_LAST) begin
            state_nx = ST_RUN;
            s_nx     = s_q + SW'(1);
            j_nx     = '0;
          end else begin
            state_nx = ST_DONE;
          end
        end else begin
          d_nx = d_q + DW'(1);
        end
      end
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Output next values derived from the next state; addresses hold outside RUN
  always_comb begin
    rd_en_nx  = (state_nx == ST_RUN);
    busy_nx   = (state_nx == ST_RUN) || (state_nx == ST_DRAIN);
    done_nx   = (state_nx == ST_DONE);
    addr_a_nx = rd_addr_a;
    addr_b_nx = rd_addr_b;
    tw_nx     = twiddle_address;
    stage_nx  = stage;
    if (state_nx == ST_RUN) begin
      addr_a_nx = AW'(rotl(32'({j_nx, 1'b0}), 32'(s_nx), AW));
      addr_b_nx = AW'(rotl(32'({j_nx, 1'b1}), 32'(s_nx), AW));
      tw_nx     = j_nx & TW'(stage_mask(32'(s_nx), TW));
      stage_nx  = s_nx;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_en           <= 1'b0;
      fft_busy        <= 1'b0;
      fft_done        <= 1'b0;
      rd_addr_a       <= '0;
      rd_addr_b       <= '0;
      twiddle_address <= '0;
      stage           <= '0;
    end else begin
      rd_en           <= rd_en_nx;
      fft_busy        <= busy_nx;
      fft_done        <= done_nx;
      rd_addr_a       <= addr_a_nx;
      rd_addr_b       <= addr_b_nx;
      twiddle_address <= tw_nx;
      stage           <= stage_nx;
    end
  end

`ifdef FFT_AGU_IFFT_EN
  logic inv_q;
  logic inv_nx;

  // Direction is captured on the accepted start edge only
  always_comb begin
    inv_nx = inv_q;
    if ((state == ST_IDLE) && start_edge_c) inv_nx = fft_inverse;
  end

  // Held direction flag and its busy-qualified output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inv_q   <= 1'b0;
      tw_conj <= 1'b0;
    end else begin
      inv_q   <= inv_nx;
      tw_conj <= busy_nx & inv_nx;
    end
  end
`endif

  fft_agu_wb_pipe #(
    .DEPTH(BFLY_LAT),
    .WIDTH(PW)
  ) u_wb_pipe (
    .clk  (clk),
    .reset(reset),
    .d    ({rd_en, rd_addr_a, rd_addr_b}),
    .q    (wb_q)
  );

  assign {mem_wr, wr_addr_a, wr_addr_b} = wb_q;

endmodule

// File: tb/tb_fft_agu_param.sv
// Scoreboard bench for fft_agu_param (N=32/LAT=3 main instance, N=8/LAT=1 second).
module tb_fft_agu_param;

  localparam int LOG2N = 5;
  localparam int BFLY  = 3;
  localparam int N     = 32;
  localparam int AW    = 5;
  localparam int TW    = 4;
  localparam int TOTAL = LOG2N * (N / 2 + BFLY);

  logic clk = 1'b0;
  logic reset, fft_start, start3;
  always #5 clk = ~clk;

  logic          fft_busy, fft_done, rd_en, mem_wr;
  logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [TW-1:0] twiddle_address;
  logic [2:0]    stage;

  logic       busy3, done3, rd_en3, mw3;
  logic [2:0] a3, b3, wa3, wb3;
  logic [1:0] tw3, stage3;

`ifdef FFT_AGU_IFFT_EN
  logic fft_inverse, tw_conj, fft_inverse3, tw_conj3;
`endif

  fft_agu_param #(.LOG2N(LOG2N), .BFLY_LAT(BFLY)) u_dut (
    .clk(clk), .reset(reset), .fft_start(fft_start),
`ifdef FFT_AGU_IFFT_EN
    .fft_inverse(fft_inverse), .tw_conj(tw_conj),
`endif
    .fft_busy(fft_busy), .fft_done(fft_done), .rd_en(rd_en),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .twiddle_address(twiddle_address),
    .mem_wr(mem_wr), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b), .stage(stage)
  );

  fft_agu_param #(.LOG2N(3), .BFLY_LAT(1)) u_dut3 (
    .clk(clk), .reset(reset), .fft_start(start3),
`ifdef FFT_AGU_IFFT_EN
    .fft_inverse(fft_inverse3), .tw_conj(tw_conj3),
`endif
    .fft_busy(busy3), .fft_done(done3), .rd_en(rd_en3),
    .rd_addr_a(a3), .rd_addr_b(b3), .twiddle_address(tw3),
    .mem_wr(mw3), .wr_addr_a(wa3), .wr_addr_b(wb3), .stage(stage3)
  );

  int checks = 0;
  int errors = 0;

  typedef struct { int a; int b; int tw; int st; } rd_exp_t;
  typedef struct { int a; int b; } wr_exp_t;
  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference addressing: rotate the AW-bit leg index by s, mask top s twiddle bits
  function automatic void push_model();
    for (int s = 0; s < LOG2N; s++) begin
      for (int j = 0; j < N / 2; j++) begin
        rd_exp_t r;
        wr_exp_t w;
        int va, vb, m;
        va = 2 * j;
        vb = 2 * j + 1;
        r.a  = ((va << s) | (va >> (AW - s))) & (N - 1);
        r.b  = ((vb << s) | (vb >> (AW - s))) & (N - 1);
        m    = (((1 << s) - 1) << (TW - s)) & ((1 << TW) - 1);
        r.tw = j & m;
        r.st = s;
        w.a  = r.a;
        w.b  = r.b;
        rd_q.push_back(r);
        wr_q.push_back(w);
      end
    end
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_busy"}, fft_busy, 0);
    check({tag, "_done"}, fft_done, 0);
    check({tag, "_mem_wr"}, mem_wr, 0);
    check({tag, "_rd_a"}, rd_addr_a, 0);
    check({tag, "_rd_b"}, rd_addr_b, 0);
    check({tag, "_tw"}, twiddle_address, 0);
    check({tag, "_wr_a"}, wr_addr_a, 0);
    check({tag, "_wr_b"}, wr_addr_b, 0);
    check({tag, "_stage"}, stage, 0);
  endtask

  // mode 0: plain run, 1: start toggled while busy, 2: reset at cycle 40
  task automatic run(input int mode, input bit inv,
                     output int busy_n, output int rd_n, output int done_n,
                     output int done_cyc, output int first_rd, output int first_wr,
                     output int last_wr, output int gap_n);
    busy_n = 0; rd_n = 0; done_n = 0; done_cyc = 0;
    first_rd = 0; first_wr = 0; last_wr = 0; gap_n = 0;
    @(negedge clk);
    fft_start = 1'b0;
`ifdef FFT_AGU_IFFT_EN
    fft_inverse = inv;
`endif
    @(negedge clk);
    fft_start = 1'b1;
    push_model();
    for (int cyc = 1; cyc <= TOTAL + 20; cyc++) begin
      bit exp_busy;
      @(negedge clk);
      exp_busy = (cyc <= TOTAL) && !(mode == 2 && cyc > 40);
      check($sformatf("busy_c%0d", cyc), fft_busy, exp_busy);
      check($sformatf("done_c%0d", cyc), fft_done, (mode != 2) && (cyc == TOTAL + 1));
`ifdef FFT_AGU_IFFT_EN
      check($sformatf("tw_conj_c%0d", cyc), tw_conj, exp_busy & inv);
`endif
      if (fft_busy) busy_n++;
      if (fft_busy && !rd_en) gap_n++;
      if (fft_done) begin done_n++; done_cyc = cyc; end
      if (rd_en) begin
        rd_n++;
        if (first_rd == 0) first_rd = cyc;
        check($sformatf("rd_pending_c%0d", cyc), int'(rd_q.size() > 0), 1);
        if (rd_q.size() > 0) begin
          rd_exp_t r;
          r = rd_q.pop_front();
          check($sformatf("rd_a_s%0d_c%0d", r.st, cyc), rd_addr_a, r.a);
          check($sformatf("rd_b_s%0d_c%0d", r.st, cyc), rd_addr_b, r.b);
          check($sformatf("tw_s%0d_c%0d", r.st, cyc), twiddle_address, r.tw);
          check($sformatf("stage_c%0d", cyc), stage, r.st);
        end
      end
      if (mem_wr) begin
        if (first_wr == 0) first_wr = cyc;
        last_wr = cyc;
        check($sformatf("wr_pending_c%0d", cyc), int'(wr_q.size() > 0), 1);
        if (wr_q.size() > 0) begin
          wr_exp_t w;
          w = wr_q.pop_front();
          check($sformatf("wr_a_c%0d", cyc), wr_addr_a, w.a);
          check($sformatf("wr_b_c%0d", cyc), wr_addr_b, w.b);
        end
      end
      if (mode == 1 && (cyc == 20 || cyc == 60)) fft_start = 1'b0;
      if (mode == 1 && (cyc == 21 || cyc == 61)) fft_start = 1'b1;
`ifdef FFT_AGU_IFFT_EN
      if (cyc == 30) fft_inverse = ~inv;
`endif
      if (mode == 2 && cyc == 40) begin
        reset = 1'b1;
        fft_start = 1'b0;
        #1;
        check_all_zero("abort");
        rd_q.delete();
        wr_q.delete();
      end
      if (mode == 2 && cyc == 41) reset = 1'b0;
    end
  endtask

  task automatic check_run(input string tag, input int busy_n, input int rd_n,
                           input int done_n, input int done_cyc, input int first_rd,
                           input int first_wr, input int last_wr, input int gap_n);
    check({tag, "_busy_cycles"}, busy_n, TOTAL);
    check({tag, "_rd_cycles"}, rd_n, LOG2N * N / 2);
    check({tag, "_done_pulses"}, done_n, 1);
    check({tag, "_done_cycle"}, done_cyc, TOTAL + 1);
    check({tag, "_first_rd"}, first_rd, 1);
    check({tag, "_first_wr"}, first_wr, 1 + BFLY);
    check({tag, "_last_wr"}, last_wr, TOTAL);
    check({tag, "_drain_gaps"}, gap_n, LOG2N * BFLY);
    check({tag, "_rd_left"}, rd_q.size(), 0);
    check({tag, "_wr_left"}, wr_q.size(), 0);
  endtask

  initial begin
    int bn, rn, dn, dc, fr, fw, lw, gn, busy3_n;
    reset = 1'b1;
    fft_start = 1'b0;
    start3 = 1'b0;
`ifdef FFT_AGU_IFFT_EN
    fft_inverse = 1'b0;
    fft_inverse3 = 1'b1;
`endif
    repeat (2) @(negedge clk);
    check_all_zero("reset");
`ifdef FFT_AGU_IFFT_EN
    check("reset_tw_conj", tw_conj, 0);
`endif
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Full forward/inverse run with scoreboard on every read and write-back
    run(0, 1'b1, bn, rn, dn, dc, fr, fw, lw, gn);
    check_run("run1", bn, rn, dn, dc, fr, fw, lw, gn);

    // Start held and re-toggled while busy must not restart
    run(1, 1'b0, bn, rn, dn, dc, fr, fw, lw, gn);
    check_run("toggle", bn, rn, dn, dc, fr, fw, lw, gn);

    // Fresh edge after DONE gives an identical run
    run(0, 1'b0, bn, rn, dn, dc, fr, fw, lw, gn);
    check_run("run2", bn, rn, dn, dc, fr, fw, lw, gn);

    // Reset mid-transform: no done pulse, then a clean run from stage 0
    run(2, 1'b0, bn, rn, dn, dc, fr, fw, lw, gn);
    check("abort_done_pulses", dn, 0);
    check("abort_busy_cycles", bn, 40);
    run(0, 1'b0, bn, rn, dn, dc, fr, fw, lw, gn);
    check_run("post_abort", bn, rn, dn, dc, fr, fw, lw, gn);

    // Small instance: N=8, one-cycle butterfly
    busy3_n = 0;
    @(negedge clk);
    start3 = 1'b1;
    for (int cyc = 1; cyc <= 25; cyc++) begin
      @(negedge clk);
      if (busy3) busy3_n++;
      check($sformatf("n8_busy_c%0d", cyc), busy3, cyc <= 15);
      check($sformatf("n8_done_c%0d", cyc), done3, cyc == 16);
`ifdef FFT_AGU_IFFT_EN
      check($sformatf("n8_tw_conj_c%0d", cyc), tw_conj3, cyc <= 15);
`endif
      if (cyc == 8) begin
        check("n8_s1j2_rd_en", rd_en3, 1);
        check("n8_s1j2_stage", stage3, 1);
        check("n8_s1j2_rd_a", a3, 1);
        check("n8_s1j2_rd_b", b3, 3);
        check("n8_s1j2_tw", tw3, 2);
      end
      if (cyc == 9) begin
        check("n8_s1j2_wr_en", mw3, 1);
        check("n8_s1j2_wr_a", wa3, 1);
        check("n8_s1j2_wr_b", wb3, 3);
      end
    end
    check("n8_busy_cycles", busy3_n, 15);
    start3 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
